addr_mode_sequencer: RTL

- Cycle-level T-state sequencer for the 6502 core; steps every instruction through opcode fetch, operand fetch, addressing-mode cycles and the memory-access tail.
- Sits between the opcode decoder (mode, access class) and the datapath (address mux, PC, address latches, ALU writeback).
- Branch, stack, jump, BRK and interrupt flows are handed to an external micro-sequencer through a req/done handshake.
- Cycle counts match NMOS 6502 documented timing for all handled modes.

---
 rtl/addr_mode_sequencer_if.sv | 43 ++++
 rtl/addr_mode_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/addr_mode_sequencer_if.sv
// Decoder/datapath bundle for the 6502 T-state sequencer.
// master = sequencer side, slave = decoder/datapath/test side.
interface addr_mode_sequencer_if;
  logic       i_rdy;
  logic [2:0] i_mode;
  logic       i_jam;
  logic       i_single_byte;
  logic       i_read;
  logic       i_load;
  logic       i_store;
  logic       i_rmw;
  logic       i_page_cross;
  logic       i_ext_done;

  logic [4:0] o_state;
  logic       o_sync;
  logic       o_ir_load;
  logic       o_pc_inc;
  logic [2:0] o_addr_sel;
  logic       o_rw;
  logic       o_adl_load;
  logic       o_adh_load;
  logic       o_idx_add;
  logic       o_adh_fix;
  logic       o_alu_exec;
  logic       o_wb;
  logic       o_ext_req;
  logic       o_jam;

  modport master (
    input  i_rdy, i_mode, i_jam, i_single_byte, i_read, i_load, i_store, i_rmw,
           i_page_cross, i_ext_done,
    output o_state, o_sync, o_ir_load, o_pc_inc, o_addr_sel, o_rw, o_adl_load,
           o_adh_load, o_idx_add, o_adh_fix, o_alu_exec, o_wb, o_ext_req, o_jam
  );

  modport slave (
    output i_rdy, i_mode, i_jam, i_single_byte, i_read, i_load, i_store, i_rmw,
           i_page_cross, i_ext_done,
    input  o_state, o_sync, o_ir_load, o_pc_inc, o_addr_sel, o_rw, o_adl_load,
           o_adh_load, o_idx_add, o_adh_fix, o_alu_exec, o_wb, o_ext_req, o_jam
  );
endinterface

// File: rtl/addr_mode_sequencer.sv
// 6502 T-state sequencer: fetch, operand, addressing-mode and memory-tail cycles.
// Outputs are combinational from state and latched mode/class; i_rdy low freezes read cycles.
module addr_mode_sequencer #(
  parameter bit JAM_STICKY = 1'b1
) (
  input logic                   i_clk,
  input logic                   i_rst,
  addr_mode_sequencer_if.master bus
);

  typedef enum logic [4:0] {
    ST_FETCH  = 5'd0,
    ST_DECODE = 5'd1,
    ST_ZX     = 5'd2,
    ST_AH     = 5'd3,
    ST_FIX    = 5'd4,
    ST_XI     = 5'd5,
    ST_PL     = 5'd6,
    ST_PH     = 5'd7,
    ST_MEM    = 5'd8,
    ST_MOD    = 5'd9,
    ST_WR     = 5'd10,
    ST_EXT    = 5'd11,
    ST_JAM    = 5'd31
  } state_e;

  localparam logic [2:0] M_IMM   = 3'd0;
  localparam logic [2:0] M_ZPG   = 3'd1;
  localparam logic [2:0] M_ZPGXY = 3'd2;
  localparam logic [2:0] M_ABS   = 3'd3;
  localparam logic [2:0] M_ABSXY = 3'd4;
  localparam logic [2:0] M_XIND  = 3'd5;
  localparam logic [2:0] M_INDY  = 3'd6;
  localparam logic [2:0] M_EXT   = 3'd7;

  localparam logic [2:0] AS_PC   = 3'd0;
  localparam logic [2:0] AS_ZP   = 3'd1;
  localparam logic [2:0] AS_ABS  = 3'd2;
  localparam logic [2:0] AS_PTR  = 3'd3;
  localparam logic [2:0] AS_PTR1 = 3'd4;

  state_e     state_q, state_d;
  logic [2:0] mode_q, mode_d;
  logic       read_q, read_d, load_q, load_d, store_q, store_d, rmw_q, rmw_d;
  logic       pcross_q, pcross_d;

  logic       sync_c, ir_load_c, pc_inc_c, rw_c, adl_c, adh_c, idx_c, fix_c;
  logic       alu_c, wb_c, ext_c, jam_c;
  logic [2:0] addr_c, mem_as;
  logic       stall, kill;

  assign mem_as = (mode_q == M_ZPG || mode_q == M_ZPGXY) ? AS_ZP : AS_ABS;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    read_d    = read_q;
    load_d    = load_q;
    store_d   = store_q;
    rmw_d     = rmw_q;
    pcross_d  = pcross_q;
    sync_c    = 1'b0;
    ir_load_c = 1'b0;
    pc_inc_c  = 1'b0;
    rw_c      = 1'b1;
    addr_c    = AS_PC;
    adl_c     = 1'b0;
    adh_c     = 1'b0;
    idx_c     = 1'b0;
    fix_c     = 1'b0;
    alu_c     = 1'b0;
    wb_c      = 1'b0;
    ext_c     = 1'b0;
    jam_c     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        sync_c    = 1'b1;
        ir_load_c = 1'b1;
        pc_inc_c  = 1'b1;
        state_d   = ST_DECODE;
      end
      ST_DECODE: begin
        pc_inc_c = ~bus.i_single_byte;
        mode_d   = bus.i_mode;
        read_d   = bus.i_read;
        load_d   = bus.i_load;
        store_d  = bus.i_store;
        rmw_d    = bus.i_rmw;
        if (bus.i_jam) begin
          state_d = ST_JAM;
        end else if (bus.i_mode == M_IMM) begin
          alu_c   = 1'b1;
          wb_c    = 1'b1;
          state_d = ST_FETCH;
        end else if (bus.i_mode == M_EXT) begin
          state_d = ST_EXT;
        end else begin
          adl_c = 1'b1;
          case (bus.i_mode)
            M_ZPG:   state_d = ST_MEM;
            M_ZPGXY: state_d = ST_ZX;
            M_XIND:  state_d = ST_XI;
            M_INDY:  state_d = ST_PL;
            default: state_d = ST_AH;
          endcase
        end
      end
      ST_ZX: begin
        addr_c  = AS_ZP;
        idx_c   = 1'b1;
        state_d = ST_MEM;
      end
      ST_AH: begin
        adh_c    = 1'b1;
        pc_inc_c = 1'b1;
        pcross_d = bus.i_page_cross;
        if (mode_q == M_ABSXY) begin
          idx_c   = 1'b1;
          state_d = (bus.i_page_cross | store_q | rmw_q) ? ST_FIX : ST_MEM;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_XI: begin
        addr_c  = AS_PTR;
        idx_c   = 1'b1;
        state_d = ST_PL;
      end
      ST_PL: begin
        addr_c  = AS_PTR;
        adl_c   = 1'b1;
        state_d = ST_PH;
      end
      ST_PH: begin
        addr_c   = AS_PTR1;
        adh_c    = 1'b1;
        pcross_d = bus.i_page_cross;
        if (mode_q == M_INDY) begin
          idx_c   = 1'b1;
          state_d = (bus.i_page_cross | store_q | rmw_q) ? ST_FIX : ST_MEM;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_FIX: begin
        // Carry captured in AH/PH; the live input is not trusted here.
        addr_c  = AS_ABS;
        fix_c   = pcross_q;
        state_d = ST_MEM;
      end
      ST_MEM: begin
        addr_c = mem_as;
        if (store_q) begin
          rw_c    = 1'b0;
          wb_c    = 1'b1;
          state_d = ST_FETCH;
        end else if (rmw_q) begin
          alu_c   = 1'b1;
          state_d = ST_MOD;
        end else begin
          alu_c   = read_q | load_q;
          wb_c    = read_q | load_q;
          state_d = ST_FETCH;
        end
      end
      ST_MOD: begin
        addr_c  = mem_as;
        rw_c    = 1'b0;
        state_d = ST_WR;
      end
      ST_WR: begin
        addr_c  = mem_as;
        rw_c    = 1'b0;
        wb_c    = 1'b1;
        state_d = ST_FETCH;
      end
      ST_EXT: begin
        ext_c = 1'b1;
        if (bus.i_ext_done) state_d = ST_FETCH;
      end
      ST_JAM: begin
        jam_c = 1'b1;
        if (!JAM_STICKY && bus.i_ext_done) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // EXT hands the bus to the micro-sequencer, so local bus ready does not gate it.
  assign stall = rw_c & ~bus.i_rdy & (state_q != ST_EXT);
  assign kill  = stall | i_rst;

  always_comb begin
    bus.o_state    = state_q;
    bus.o_sync     = sync_c & ~i_rst;
    bus.o_ir_load  = ir_load_c & ~kill;
    bus.o_pc_inc   = pc_inc_c & ~kill;
    bus.o_addr_sel = i_rst ? AS_PC : addr_c;
    bus.o_rw       = rw_c | i_rst;
    bus.o_adl_load = adl_c & ~kill;
    bus.o_adh_load = adh_c & ~kill;
    bus.o_idx_add  = idx_c & ~kill;
    bus.o_adh_fix  = fix_c & ~kill;
    bus.o_alu_exec = alu_c & ~kill;
    bus.o_wb       = wb_c & ~kill;
    bus.o_ext_req  = ext_c & ~kill;
    bus.o_jam      = jam_c & ~i_rst;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_FETCH;
      mode_q   <= 3'd0;
      read_q   <= 1'b0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      rmw_q    <= 1'b0;
      pcross_q <= 1'b0;
    end else if (!stall) begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      read_q   <= read_d;
      load_q   <= load_d;
      store_q  <= store_d;
      rmw_q    <= rmw_d;
      pcross_q <= pcross_d;
    end
  end

endmodule
